// File: rtl/quad_stim_gen.sv
// Quadrature stimulus generator: turns step commands into A/B edges at a fixed
// rate, with optional deterministic chatter on the line that just changed.
module quad_stim_gen #(
  parameter int STEP_DIV   = 16,
  parameter int CNT_WIDTH  = 8,
  parameter int BOUNCE_LEN = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dir,
  input  logic [CNT_WIDTH-1:0] cmd_steps,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 enc_a,
  output logic                 enc_b,
  output logic [CNT_WIDTH-1:0] position
);

  localparam int DIV_W = $clog2(STEP_DIV);
  localparam int BNC_W = $clog2(STEP_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [BNC_W-1:0] BNC_LAST = BNC_W'(BOUNCE_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_HOLD} state_t;

  state_t               state_q;
  logic [DIV_W-1:0]     div_q;
  logic [CNT_WIDTH-1:0] rem_q;
  logic [CNT_WIDTH-1:0] pos_q;
  logic                 dir_q;
  logic                 a_q, b_q;
  logic                 enc_a_q, enc_b_q;
  logic                 done_q;
  logic [BNC_W-1:0]     bnc_q;
  logic                 bnc_on_a_q;

  // Gray step: going up, A toggles when A==B; going down, A toggles when A!=B.
  logic flip_a_d;
  logic a_d, b_d;
  assign flip_a_d = ((a_q == b_q) == dir_q);
  assign a_d      = a_q ^ flip_a_d;
  assign b_d      = b_q ^ ~flip_a_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      rem_q      <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      enc_a_q    <= 1'b0;
      enc_b_q    <= 1'b0;
      done_q     <= 1'b0;
      bnc_q      <= '0;
      bnc_on_a_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Chatter runs on its own counter so an abort never cuts it short.
      if (bnc_q != '0) begin
        enc_a_q <= a_q ^ (bnc_on_a_q & bnc_q[0]);
        enc_b_q <= b_q ^ (~bnc_on_a_q & bnc_q[0]);
        bnc_q   <= (bnc_q == BNC_LAST) ? '0 : bnc_q + BNC_W'(1);
      end else begin
        enc_a_q <= a_q;
        enc_b_q <= b_q;
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            dir_q <= cmd_dir;
            rem_q <= cmd_steps;
            // The accept edge counts as the first divider tick.
            div_q <= DIV_W'(1);
            if (cmd_steps == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_STEP;
            end
          end
        end
        S_STEP: begin
          if (div_q == DIV_LAST) begin
            a_q        <= a_d;
            b_q        <= b_d;
            enc_a_q    <= a_d;
            enc_b_q    <= b_d;
            bnc_on_a_q <= flip_a_d;
            bnc_q      <= (BOUNCE_LEN > 1) ? BNC_W'(1) : '0;
            pos_q      <= dir_q ? pos_q + CNT_WIDTH'(1) : pos_q - CNT_WIDTH'(1);
            rem_q      <= rem_q - CNT_WIDTH'(1);
            div_q      <= '0;
            if (rem_q == CNT_WIDTH'(1) || abort) begin
              state_q <= S_HOLD;
            end
          end else if (abort) begin
            state_q <= S_HOLD;
            div_q   <= DIV_W'(1);
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (div_q == DIV_LAST) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            div_q   <= '0;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign enc_a     = enc_a_q;
  assign enc_b     = enc_b_q;
  assign position  = pos_q;

endmodule
